// File: rtl/dmem_copy_engine.sv
// Data-memory initiator that copies (src->dst) or fills (constant->dst) a block of len words.
// All memory strobes, address and write data are registered Moore outputs of the transfer FSM.
module dmem_copy_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode_fill,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFinish} state_e;

  state_e            state_q;
  logic              fill_mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] fill_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W-1:0]  idx_next;

  assign idx_next = idx_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      fill_mode_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      fill_q      <= '0;
      idx_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      words_done  <= '0;
      DataAddress <= '0;
      ReadMem     <= 1'b0;
      WriteMem    <= 1'b0;
      DataIn      <= '0;
    end else begin
      // Pulses and strobes drop unless the next state re-asserts them.
      done        <= 1'b0;
      aborted     <= 1'b0;
      ReadMem     <= 1'b0;
      WriteMem    <= 1'b0;
      DataAddress <= '0;
      DataIn      <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            fill_mode_q <= mode_fill;
            src_q       <= src;
            dst_q       <= dst;
            len_q       <= len;
            fill_q      <= fill_value;
            idx_q       <= '0;
            words_done  <= '0;
            busy        <= 1'b1;
            if (len == '0) begin
              state_q <= StFinish;
              done    <= 1'b1;
            end else if (mode_fill) begin
              state_q     <= StWrite;
              WriteMem    <= 1'b1;
              DataAddress <= dst;
              DataIn      <= fill_value;
            end else begin
              state_q     <= StRead;
              ReadMem     <= 1'b1;
              DataAddress <= src;
            end
          end
        end
        StRead: begin
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            // DataIn doubles as the read buffer for the following write.
            state_q     <= StWrite;
            WriteMem    <= 1'b1;
            DataAddress <= dst_q + ADDR_W'(idx_q);
            DataIn      <= DataOut;
          end
        end
        StWrite: begin
          words_done <= idx_next;
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (idx_next == len_q) begin
            state_q <= StFinish;
            done    <= 1'b1;
          end else begin
            idx_q <= idx_next;
            if (fill_mode_q) begin
              state_q     <= StWrite;
              WriteMem    <= 1'b1;
              DataAddress <= dst_q + ADDR_W'(idx_next);
              DataIn      <= fill_q;
            end else begin
              state_q     <= StRead;
              ReadMem     <= 1'b1;
              DataAddress <= src_q + ADDR_W'(idx_next);
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          aborted <= abort;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Self-checking bench: directed and randomized copy/fill transfers against a word-level RAM model.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        mode_fill = 1'b0;
  logic [15:0] src = '0;
  logic [15:0] dst = '0;
  logic [8:0]  len = '0;
  logic [15:0] fill_value = '0;
  logic        abort = 1'b0;
  logic        busy, done, aborted;
  logic [8:0]  words_done;
  logic [15:0] data_address;
  logic        read_mem, write_mem;
  logic [15:0] data_in, data_out;

  always #5 clk = ~clk;

  dmem_copy_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode_fill   (mode_fill),
    .src         (src),
    .dst         (dst),
    .len         (len),
    .fill_value  (fill_value),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .words_done  (words_done),
    .DataAddress (data_address),
    .ReadMem     (read_mem),
    .WriteMem    (write_mem),
    .DataIn      (data_in),
    .DataOut     (data_out)
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] exp_mem [0:65535];
  logic [15:0] wlog [$];
  int n_reads, n_writes, n_both;
  int n_checks = 0;
  int n_errors = 0;

  assign data_out = read_mem ? mem[data_address] : 16'h0000;

  always @(posedge clk) begin
    if (write_mem) begin
      mem[data_address] <= data_in;
      wlog.push_back(data_address);
      n_writes++;
    end
    if (read_mem) n_reads++;
    if (read_mem && write_mem) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  // Reference: ascending word-by-word transfer of the first w words.
  task automatic model(input bit fill, input logic [15:0] s, input logic [15:0] d, input int w,
                       input logic [15:0] fv);
    for (int i = 0; i < w; i++) begin
      logic [15:0] ra, wa;
      ra = s + 16'(i);
      wa = d + 16'(i);
      exp_mem[wa] = fill ? fv : exp_mem[ra];
    end
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic clear_counts();
    n_reads  = 0;
    n_writes = 0;
    wlog.delete();
  endtask

  // Cycle 1 is the cycle right after the start edge; abort_k>0 asserts abort during cycle abort_k.
  task automatic run_xfer(input bit fill, input logic [15:0] s, input logic [15:0] d,
                          input logic [8:0] l, input logic [15:0] fv, input int abort_k,
                          input bit abort_with_start, output int cyc, output bit got_done,
                          output bit got_abort);
    @(posedge clk); #1;
    start = 1'b1; mode_fill = fill; src = s; dst = d; len = l; fill_value = fv;
    abort = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    src = 16'($urandom); dst = 16'($urandom); len = 9'($urandom);
    fill_value = 16'($urandom); mode_fill = 1'($urandom);
    cyc = 1; got_done = 1'b0; got_abort = 1'b0;
    while (cyc <= 600) begin
      if (done) got_done = 1'b1;
      if (aborted) got_abort = 1'b1;
      if (got_done || got_abort) break;
      abort = (cyc == abort_k);
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0;
  endtask

  function automatic int exp_words(input bit fill, input int l, input int k);
    if (k == 0) return l;
    return fill ? k : k / 2;
  endfunction

  function automatic int exp_cycle(input bit fill, input int l, input int k);
    if (k != 0) return k + 1;
    return fill ? l + 1 : 2 * l + 1;
  endfunction

  initial begin
    int  cyc;
    bit  gd, ga;
    bit  f;
    int  l, k, w;
    logic [15:0] s, d, fv;

    for (int a = 0; a < 65536; a++) begin
      mem[a] = (a < 256) ? 16'($urandom) : 16'h0000;
      exp_mem[a] = mem[a];
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_strobes", {done, aborted, read_mem, write_mem}, 0);
    check("rst_regs", {words_done, data_address, data_in}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed copy
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 16'(i + 1);
      exp_mem[16 + i] = 16'(i + 1);
    end
    clear_counts();
    run_xfer(1'b0, 16'h0010, 16'h0040, 9'd4, 16'h0, 0, 1'b0, cyc, gd, ga);
    model(1'b0, 16'h0010, 16'h0040, 4, 16'h0);
    check("copy_cycle", cyc, 9);
    check("copy_done", {gd, ga}, 2'b10);
    check("copy_words", words_done, 4);
    check("copy_busy_in_finish", busy, 1);
    check_mem("copy_mem");
    @(posedge clk); #1;
    check("copy_idle_busy", busy, 0);
    check("copy_done_pulse", done, 0);

    // Directed fill
    clear_counts();
    run_xfer(1'b1, 16'h0000, 16'h0080, 9'd3, 16'hBEEF, 0, 1'b0, cyc, gd, ga);
    model(1'b1, 16'h0, 16'h0080, 3, 16'hBEEF);
    check("fill_cycle", cyc, 4);
    check("fill_reads", n_reads, 0);
    check("fill_words", words_done, 3);
    check_mem("fill_mem");

    // Zero length
    clear_counts();
    run_xfer(1'b0, 16'h0005, 16'h0006, 9'd0, 16'h0, 0, 1'b0, cyc, gd, ga);
    check("len0_cycle", cyc, 1);
    check("len0_access", n_reads + n_writes, 0);
    check("len0_words", words_done, 0);

    // Abort during the third WRITE of an 8-word copy
    clear_counts();
    run_xfer(1'b0, 16'h0020, 16'h00A0, 9'd8, 16'h0, 6, 1'b0, cyc, gd, ga);
    model(1'b0, 16'h0020, 16'h00A0, 3, 16'h0);
    check("abort_flags", {gd, ga}, 2'b01);
    check("abort_words", words_done, 3);
    check("abort_busy", busy, 0);
    check_mem("abort_mem");
    repeat (3) @(posedge clk); #1;
    check("abort_no_done", done, 0);
    check("abort_quiet", n_writes, 3);

    // Abort in IDLE is ignored; abort with start is ignored
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort", {aborted, busy}, 0);
    clear_counts();
    run_xfer(1'b1, 16'h0, 16'h00C0, 9'd2, 16'h1234, 0, 1'b1, cyc, gd, ga);
    model(1'b1, 16'h0, 16'h00C0, 2, 16'h1234);
    check("start_abort_flags", {gd, ga}, 2'b10);
    check_mem("start_abort_mem");

    // Address wrap
    clear_counts();
    run_xfer(1'b1, 16'h0, 16'hFFFF, 9'd2, 16'h5A5A, 0, 1'b0, cyc, gd, ga);
    model(1'b1, 16'h0, 16'hFFFF, 2, 16'h5A5A);
    check("wrap_count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("wrap_addr0", wlog[0], 16'hFFFF);
      check("wrap_addr1", wlog[1], 16'h0000);
    end
    check("wrap_mem_hi", mem[16'hFFFF], 16'h5A5A);
    check_mem("wrap_mem");

    // Async reset mid-copy: one word committed, then outputs clear without a clock edge
    @(posedge clk); #1;
    start = 1'b1; mode_fill = 1'b0; src = 16'h0030; dst = 16'h0070; len = 9'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("areset_busy", {busy, done, aborted}, 0);
    check("areset_strobes", {read_mem, write_mem}, 0);
    check("areset_regs", {words_done, data_address, data_in}, 0);
    model(1'b0, 16'h0030, 16'h0070, 1, 16'h0);
    check_mem("areset_mem");
    @(negedge clk) rst_n = 1'b1;
    clear_counts();
    run_xfer(1'b0, 16'h0030, 16'h0070, 9'd6, 16'h0, 0, 1'b0, cyc, gd, ga);
    model(1'b0, 16'h0030, 16'h0070, 6, 16'h0);
    check("rerun_cycle", cyc, 13);
    check("rerun_words", words_done, 6);
    check_mem("rerun_mem");

    // Randomized transfers, some aborted, some overlapping
    for (int t = 0; t < 25; t++) begin
      f  = 1'($urandom_range(0, 1));
      l  = $urandom_range(0, 24);
      s  = 16'($urandom_range(0, 200));
      d  = 16'($urandom_range(0, 200));
      fv = 16'($urandom);
      k  = 0;
      if (l != 0 && $urandom_range(0, 2) == 0) k = $urandom_range(1, f ? l : 2 * l);
      w = exp_words(f, l, k);
      clear_counts();
      run_xfer(f, s, d, 9'(l), fv, k, 1'b0, cyc, gd, ga);
      model(f, s, d, w, fv);
      check("rnd_cycle", cyc, exp_cycle(f, l, k));
      check("rnd_flags", {gd, ga}, (k == 0) ? 2'b10 : 2'b01);
      check("rnd_words", words_done, w);
      check("rnd_writes", n_writes, w);
      check("rnd_reads", n_reads, f ? 0 : ((k == 0) ? l : (k + 1) / 2));
      check_mem("rnd_mem");
    end

    check("never_both_strobes", n_both, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
